// File: rtl/bcd_timer.sv
// ---------------------------------------------------------------------------
// bcd_timer
//   Two-digit BCD countdown timer feeding the seven-segment decoder. Loaded
//   with a tens/ones pair, counts down once per prescaled tick while running,
//   supports pause/resume, and pulses DONE when the count reaches 00.
//
// Optional build macro:
//   BCD_TIMER_AUTORELOAD_EN - on expiry, keep running and reload the count
//                             from the last loaded value on the next tick.
//
// Parameters:
//   DIV      system-clock cycles per count tick (>= 2)
//
// Ports:
//   CLK      system clock, rising edge
//   RESET    synchronous active-high reset
//   LOAD     load LOAD_H/LOAD_L (digits > 9 clamp to 9), go IDLE
//   LOAD_H   tens digit to load
//   LOAD_L   ones digit to load
//   START    level start/resume request (IDLE/PAUSE with nonzero count)
//   STOP     level pause request (RUN only)
//   HBCD     registered tens digit, 0-9
//   LBCD     registered ones digit, 0-9
//   RUNNING  registered, high while in RUN
//   DONE     registered one-cycle pulse when the count reaches 00
// ---------------------------------------------------------------------------
module bcd_timer #(
  parameter int DIV = 50000000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       LOAD,
  input  logic [3:0] LOAD_H,
  input  logic [3:0] LOAD_L,
  input  logic       START,
  input  logic       STOP,
  output logic [3:0] HBCD,
  output logic [3:0] LBCD,
  output logic       RUNNING,
  output logic       DONE
);

  localparam int            PW   = $clog2(DIV);
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_EXPIRED
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

`ifdef BCD_TIMER_AUTORELOAD_EN
  // Last loaded value; only consulted when the count wraps in auto-reload.
  logic [3:0] rld_h;
  logic [3:0] rld_l;
  logic       rld_zero;
`endif

  logic       tick;
  logic       cnt_zero;
  logic       cnt_one;
  logic [3:0] dec_h;
  logic [3:0] dec_l;
  logic [3:0] clamp_h;
  logic [3:0] clamp_l;

  always_comb begin
    tick     = (state == S_RUN) && (presc == PMAX);
    cnt_zero = (HBCD == 4'd0) && (LBCD == 4'd0);
    cnt_one  = (HBCD == 4'd0) && (LBCD == 4'd1);
    // Digit-wise BCD decrement: ones borrow from tens, never a binary detour.
    if (LBCD != 4'd0) begin
      dec_l = LBCD - 4'd1;
      dec_h = HBCD;
    end else begin
      dec_l = 4'd9;
      dec_h = HBCD - 4'd1;
    end
    clamp_h  = (LOAD_H > 4'd9) ? 4'd9 : LOAD_H;
    clamp_l  = (LOAD_L > 4'd9) ? 4'd9 : LOAD_L;
`ifdef BCD_TIMER_AUTORELOAD_EN
    rld_zero = (rld_h == 4'd0) && (rld_l == 4'd0);
`endif
  end

  // Single FSM block; every output is a register. The if/else-if chain
  // encodes the input priority RESET > LOAD > STOP > START > counting.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= S_IDLE;
      presc   <= '0;
      HBCD    <= 4'd0;
      LBCD    <= 4'd0;
      RUNNING <= 1'b0;
      DONE    <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
      rld_h   <= 4'd0;
      rld_l   <= 4'd0;
`endif
    end else begin
      DONE <= 1'b0;
      if (LOAD) begin
        // Wins over a same-cycle tick: no decrement, no DONE.
        HBCD    <= clamp_h;
        LBCD    <= clamp_l;
        presc   <= '0;
        state   <= S_IDLE;
        RUNNING <= 1'b0;
`ifdef BCD_TIMER_AUTORELOAD_EN
        rld_h   <= clamp_h;
        rld_l   <= clamp_l;
`endif
      end else if (STOP && (state == S_RUN)) begin
        // Prescaler is held so resume continues the partial period; a tick
        // coinciding with STOP is deferred to the first RUN cycle.
        state   <= S_PAUSE;
        RUNNING <= 1'b0;
      end else if (START && ((state == S_IDLE) || (state == S_PAUSE))) begin
        if (!cnt_zero) begin
          state   <= S_RUN;
          RUNNING <= 1'b1;
        end
      end else if (state == S_RUN) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
`ifdef BCD_TIMER_AUTORELOAD_EN
          if (cnt_zero) begin
            // 00 has been shown for one full period; start the next lap.
            HBCD <= rld_h;
            LBCD <= rld_l;
          end else begin
            HBCD <= dec_h;
            LBCD <= dec_l;
            if (cnt_one) begin
              DONE <= 1'b1;
              if (rld_zero) begin
                state   <= S_EXPIRED;
                RUNNING <= 1'b0;
              end
            end
          end
`else
          HBCD <= dec_h;
          LBCD <= dec_l;
          if (cnt_one) begin
            DONE    <= 1'b1;
            state   <= S_EXPIRED;
            RUNNING <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_timer.sv
module tb_bcd_timer;

  localparam int DIV = 4;
`ifdef BCD_TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] LOAD_H = 4'd0;
  logic [3:0] LOAD_L = 4'd0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic [3:0] HBCD;
  logic [3:0] LBCD;
  logic       RUNNING;
  logic       DONE;

  int total = 0;
  int bad   = 0;

  bcd_timer #(.DIV(DIV)) dut (
    .CLK(CLK), .RESET(RESET), .LOAD(LOAD), .LOAD_H(LOAD_H), .LOAD_L(LOAD_L),
    .START(START), .STOP(STOP), .HBCD(HBCD), .LBCD(LBCD),
    .RUNNING(RUNNING), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Advance one edge and settle; inputs are changed only after this returns.
  task automatic clk1();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_load(input logic [3:0] h, input logic [3:0] l);
    LOAD_H = h; LOAD_L = l; LOAD = 1'b1;
    clk1();
    LOAD = 1'b0;
  endtask

  task automatic do_start();
    START = 1'b1;
    clk1();
    START = 1'b0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    clk1();
    RESET = 1'b0;
    total++; if ({HBCD, LBCD} !== 8'h00) begin bad++; $display("FAIL reset_count got=%h exp=00", {HBCD, LBCD}); end
    total++; if (RUNNING !== 1'b0) begin bad++; $display("FAIL reset_running got=%b exp=0", RUNNING); end
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", DONE); end
    do_start();
    clk1();
    total++; if (RUNNING !== 1'b0 || {HBCD, LBCD} !== 8'h00) begin
      bad++; $display("FAIL start_on_zero got run=%b cnt=%h exp run=0 cnt=00", RUNNING, {HBCD, LBCD}); end
  endtask

  task automatic test_countdown();
    int dones = 0;
    do_load(4'd1, 4'd2);
    total++; if ({HBCD, LBCD} !== 8'h12 || RUNNING !== 1'b0) begin
      bad++; $display("FAIL load_12 got cnt=%h run=%b exp cnt=12 run=0", {HBCD, LBCD}, RUNNING); end
    do_start();                       // edge N
    total++; if (RUNNING !== 1'b1 || {HBCD, LBCD} !== 8'h12) begin
      bad++; $display("FAIL start_run got run=%b cnt=%h exp run=1 cnt=12", RUNNING, {HBCD, LBCD}); end
    repeat (3) clk1();                // N+3
    total++; if ({HBCD, LBCD} !== 8'h12) begin bad++; $display("FAIL pre_tick got=%h exp=12", {HBCD, LBCD}); end
    clk1();                           // N+4
    total++; if ({HBCD, LBCD} !== 8'h11) begin bad++; $display("FAIL n4 got=%h exp=11", {HBCD, LBCD}); end
    repeat (4) clk1();                // N+8
    total++; if ({HBCD, LBCD} !== 8'h10) begin bad++; $display("FAIL n8 got=%h exp=10", {HBCD, LBCD}); end
    repeat (4) clk1();                // N+12
    total++; if ({HBCD, LBCD} !== 8'h09) begin bad++; $display("FAIL n12_borrow got=%h exp=09", {HBCD, LBCD}); end
    for (int i = 0; i < 35; i++) begin
      clk1();                         // up to N+47
      if (DONE) dones++;
    end
    total++; if ({HBCD, LBCD} !== 8'h01 || dones != 0) begin
      bad++; $display("FAIL n47 got cnt=%h dones=%0d exp cnt=01 dones=0", {HBCD, LBCD}, dones); end
    clk1();                           // N+48
    total++; if ({HBCD, LBCD} !== 8'h00 || DONE !== 1'b1 || RUNNING !== AR) begin
      bad++; $display("FAIL n48_expire got cnt=%h done=%b run=%b exp cnt=00 done=1 run=%b",
                      {HBCD, LBCD}, DONE, RUNNING, AR); end
    clk1();
    total++; if (DONE !== 1'b0) begin bad++; $display("FAIL done_width got=%b exp=0", DONE); end
    // START after expiry does not restart the count.
    do_start();
    total++; if (RUNNING !== AR || {HBCD, LBCD} !== 8'h00) begin
      bad++; $display("FAIL start_expired got run=%b cnt=%h exp run=%b cnt=00", RUNNING, {HBCD, LBCD}, AR); end
  endtask

  task automatic test_pause();
    int moved = 0;
    do_load(4'd0, 4'd3);
    do_start();                       // N
    repeat (6) clk1();                // N+6: 6 RUN cycles, count 02
    total++; if ({HBCD, LBCD} !== 8'h02) begin bad++; $display("FAIL pause_pre got=%h exp=02", {HBCD, LBCD}); end
    STOP = 1'b1;
    clk1();
    STOP = 1'b0;
    total++; if (RUNNING !== 1'b0) begin bad++; $display("FAIL pause_run got=%b exp=0", RUNNING); end
    for (int i = 0; i < 10; i++) begin
      clk1();
      if ({HBCD, LBCD} !== 8'h02 || DONE) moved++;
    end
    total++; if (moved != 0) begin bad++; $display("FAIL pause_hold got changes=%0d exp=0", moved); end
    do_start();
    total++; if (RUNNING !== 1'b1) begin bad++; $display("FAIL resume_run got=%b exp=1", RUNNING); end
    repeat (5) clk1();                // 11 RUN cycles
    total++; if ({HBCD, LBCD} !== 8'h01 || DONE !== 1'b0) begin
      bad++; $display("FAIL resume_11 got cnt=%h done=%b exp cnt=01 done=0", {HBCD, LBCD}, DONE); end
    clk1();                           // 12 RUN cycles
    total++; if ({HBCD, LBCD} !== 8'h00 || DONE !== 1'b1) begin
      bad++; $display("FAIL resume_12 got cnt=%h done=%b exp cnt=00 done=1", {HBCD, LBCD}, DONE); end
  endtask

  task automatic test_load_clamp();
    do_load(4'd12, 4'd15);
    total++; if ({HBCD, LBCD} !== 8'h99) begin bad++; $display("FAIL clamp got=%h exp=99", {HBCD, LBCD}); end
    do_start();                       // N
    repeat (3) clk1();                // N+3, tick pending on N+4
    do_load(4'd4, 4'd5);              // LOAD sampled at N+4
    total++; if ({HBCD, LBCD} !== 8'h45 || DONE !== 1'b0 || RUNNING !== 1'b0) begin
      bad++; $display("FAIL load_vs_tick got cnt=%h done=%b run=%b exp cnt=45 done=0 run=0",
                      {HBCD, LBCD}, DONE, RUNNING); end
    repeat (5) clk1();
    total++; if ({HBCD, LBCD} !== 8'h45) begin bad++; $display("FAIL load_idle_hold got=%h exp=45", {HBCD, LBCD}); end
  endtask

  task automatic test_stop_on_tick();
    do_load(4'd0, 4'd2);
    do_start();                       // N
    repeat (3) clk1();
    STOP = 1'b1;
    clk1();                           // N+4: STOP wins over the tick
    STOP = 1'b0;
    total++; if ({HBCD, LBCD} !== 8'h02 || RUNNING !== 1'b0) begin
      bad++; $display("FAIL stop_vs_tick got cnt=%h run=%b exp cnt=02 run=0", {HBCD, LBCD}, RUNNING); end
    do_start();
    total++; if ({HBCD, LBCD} !== 8'h02) begin bad++; $display("FAIL resume_edge got=%h exp=02", {HBCD, LBCD}); end
    clk1();                           // deferred tick fires immediately
    total++; if ({HBCD, LBCD} !== 8'h01) begin bad++; $display("FAIL deferred_tick got=%h exp=01", {HBCD, LBCD}); end
  endtask

  task automatic test_reset_mid_run();
    int dones = 0;
    do_load(4'd0, 4'd1);
    do_start();                       // N, tick would be N+4
    clk1();
    RESET = 1'b1;
    clk1();                           // N+2
    RESET = 1'b0;
    total++; if ({HBCD, LBCD} !== 8'h00 || RUNNING !== 1'b0 || DONE !== 1'b0) begin
      bad++; $display("FAIL reset_mid got cnt=%h run=%b done=%b exp cnt=00 run=0 done=0",
                      {HBCD, LBCD}, RUNNING, DONE); end
    for (int i = 0; i < 10; i++) begin
      clk1();
      if (DONE) dones++;
    end
    total++; if (dones != 0) begin bad++; $display("FAIL reset_no_done got pulses=%0d exp=0", dones); end
    do_start();
    total++; if (RUNNING !== 1'b0) begin bad++; $display("FAIL reset_idle got run=%b exp=0", RUNNING); end
  endtask

`ifdef BCD_TIMER_AUTORELOAD_EN
  task automatic test_autoreload();
    int runs_low = 0;
    do_load(4'd0, 4'd2);
    do_start();                       // N
    for (int lap = 0; lap < 2; lap++) begin
      for (int i = 0; i < 4; i++) begin clk1(); if (!RUNNING) runs_low++; end
      total++; if ({HBCD, LBCD} !== 8'h01) begin bad++; $display("FAIL ar_01 lap=%0d got=%h exp=01", lap, {HBCD, LBCD}); end
      for (int i = 0; i < 4; i++) begin clk1(); if (!RUNNING) runs_low++; end
      total++; if ({HBCD, LBCD} !== 8'h00 || DONE !== 1'b1) begin
        bad++; $display("FAIL ar_00 lap=%0d got cnt=%h done=%b exp cnt=00 done=1", lap, {HBCD, LBCD}, DONE); end
      for (int i = 0; i < 4; i++) begin clk1(); if (!RUNNING) runs_low++; end
      total++; if ({HBCD, LBCD} !== 8'h02) begin bad++; $display("FAIL ar_02 lap=%0d got=%h exp=02", lap, {HBCD, LBCD}); end
    end
    total++; if (runs_low != 0) begin bad++; $display("FAIL ar_running got low_cycles=%0d exp=0", runs_low); end
  endtask
`endif

  initial begin
    test_reset();
    test_countdown();
    test_pause();
    test_load_clamp();
    test_stop_on_tick();
    test_reset_mid_run();
`ifdef BCD_TIMER_AUTORELOAD_EN
    test_autoreload();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
